// File: rtl/adc_cal_filter.sv
// ADC front end: boxcar moving-average filter with min/max calibration that
// commits clamp limits for the filtered output.
module adc_cal_filter #(
    parameter int AVG_LOG2    = 3,
    parameter int CAL_SAMPLES = 256,
    parameter int MIN_SPAN    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        cal_start,
    output logic [11:0] adc_out,
    output logic        adc_out_valid,
    output logic [11:0] adc_min,
    output logic [11:0] adc_max,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_err
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 12 + AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam int CW    = $clog2(CAL_SAMPLES + 1);

    typedef enum logic [1:0] {IDLE, CAL, CHECK} state_t;

    logic [11:0]   hist_reg [DEPTH];
    logic [SW-1:0] sum_reg;
    logic [SW-1:0] sum_next;
    logic [FW-1:0] fill_cnt_reg;
    logic          s1_valid_reg;
    logic [11:0]   mean;
    logic [11:0]   clamped;
    logic [11:0]   adc_out_reg;
    logic          adc_out_valid_reg;
    logic [11:0]   adc_min_reg;
    logic [11:0]   adc_max_reg;
    logic          cal_done_reg;
    logic          cal_err_reg;
    logic [11:0]   work_min_reg;
    logic [11:0]   work_max_reg;
    logic [CW-1:0] cal_cnt_reg;
    state_t        state_reg;
    state_t        state_next;
    logic          span_ok;
    logic          commit_ok;
    logic          commit_bad;

    // Stage 1: the oldest entry leaves the running sum as the new one enters,
    // so the sum never exceeds DEPTH * 4095 and SW bits are always enough.
    assign sum_next = sum_reg + SW'(sample) - SW'(hist_reg[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) hist_reg[i] <= '0;
            sum_reg      <= '0;
            fill_cnt_reg <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= sample_valid && (fill_cnt_reg >= FW'(DEPTH - 1));
            if (sample_valid) begin
                hist_reg[0] <= sample;
                for (int i = 1; i < DEPTH; i++) hist_reg[i] <= hist_reg[i-1];
                sum_reg <= sum_next;
                if (fill_cnt_reg != FW'(DEPTH)) fill_cnt_reg <= fill_cnt_reg + FW'(1);
            end
        end
    end

    // Stage 2: mean and clamp against the committed limits only.
    assign mean = sum_reg[SW-1:AVG_LOG2];

    always_comb begin
        clamped = mean;
        if (mean < adc_min_reg)      clamped = adc_min_reg;
        else if (mean > adc_max_reg) clamped = adc_max_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_out_reg       <= '0;
            adc_out_valid_reg <= 1'b0;
        end else begin
            adc_out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) adc_out_reg <= clamped;
        end
    end

    // Calibration FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Calibration FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cal_start) state_next = CAL;
            CAL:     if (s1_valid_reg && cal_cnt_reg == CW'(CAL_SAMPLES - 1)) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Calibration FSM: outputs
    always_comb begin
        span_ok    = (int'(work_max_reg) - int'(work_min_reg)) >= MIN_SPAN;
        cal_busy   = (state_reg == CAL) || (state_reg == CHECK);
        commit_ok  = (state_reg == CHECK) && span_ok;
        commit_bad = (state_reg == CHECK) && !span_ok;
    end

    // Working extremes track the unclamped mean of every strobe seen in CAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_min_reg <= '0;
            work_max_reg <= '0;
            cal_cnt_reg  <= '0;
        end else if (state_reg == IDLE && cal_start) begin
            work_min_reg <= 12'hFFF;
            work_max_reg <= 12'h000;
            cal_cnt_reg  <= '0;
        end else if (state_reg == CAL && s1_valid_reg) begin
            if (mean < work_min_reg) work_min_reg <= mean;
            if (mean > work_max_reg) work_max_reg <= mean;
            cal_cnt_reg <= cal_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_min_reg  <= 12'h000;
            adc_max_reg  <= 12'hFFF;
            cal_done_reg <= 1'b0;
            cal_err_reg  <= 1'b0;
        end else begin
            cal_done_reg <= commit_ok;
            cal_err_reg  <= commit_bad;
            if (commit_ok) begin
                adc_min_reg <= work_min_reg;
                adc_max_reg <= work_max_reg;
            end
        end
    end

    assign adc_out       = adc_out_reg;
    assign adc_out_valid = adc_out_valid_reg;
    assign adc_min       = adc_min_reg;
    assign adc_max       = adc_max_reg;
    assign cal_done      = cal_done_reg;
    assign cal_err       = cal_err_reg;
endmodule

// File: tb/tb_adc_cal_filter.sv
// Scoreboard bench: an 8-deep filter instance and a 1-deep calibrating instance
// driven from directed vectors; a monitor pops expected outputs per strobe.
module tb_adc_cal_filter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        a_valid = 1'b0, a_cal = 1'b0;
    logic [11:0] a_sample = '0;
    logic        b_valid = 1'b0, b_cal = 1'b0;
    logic [11:0] b_sample = '0;
    logic [11:0] a_out, a_min, a_max, b_out, b_min, b_max;
    logic        a_out_valid, a_busy, a_done, a_err;
    logic        b_out_valid, b_busy, b_done, b_err;

    adc_cal_filter #(.AVG_LOG2(3)) u_a (
        .clk(clk), .reset(reset), .sample_valid(a_valid), .sample(a_sample),
        .cal_start(a_cal), .adc_out(a_out), .adc_out_valid(a_out_valid),
        .adc_min(a_min), .adc_max(a_max), .cal_busy(a_busy),
        .cal_done(a_done), .cal_err(a_err)
    );

    adc_cal_filter #(.AVG_LOG2(0), .CAL_SAMPLES(4), .MIN_SPAN(64)) u_b (
        .clk(clk), .reset(reset), .sample_valid(b_valid), .sample(b_sample),
        .cal_start(b_cal), .adc_out(b_out), .adc_out_valid(b_out_valid),
        .adc_min(b_min), .adc_max(b_max), .cal_busy(b_busy),
        .cal_done(b_done), .cal_err(b_err)
    );

    typedef struct {
        logic [11:0] val;
        int          at;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   b_done_cnt = 0, b_err_cnt = 0;
    int   d0, e0;

    logic [11:0] dn_exp   [8] = '{875, 750, 625, 500, 375, 250, 125, 0};
    logic [11:0] up_exp   [8] = '{100, 200, 300, 400, 500, 600, 700, 800};
    logic [11:0] full_exp [8] = '{1211, 1623, 2035, 2447, 2859, 3271, 3683, 4095};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (b_err)  b_err_cnt  <= b_err_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one line per output transaction, compared against the queue head.
    always @(negedge clk) begin
        if (!reset && a_out_valid) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_spurious: got strobe value %0d at cycle %0d, expected no strobe", a_out, cyc);
            end else begin
                ea = qa.pop_front();
                $display("A out cycle %0d value %0d (expected %0d)", cyc, a_out, ea.val);
                check("a_out", a_out, ea.val);
                check("a_out_cycle", cyc, ea.at);
            end
        end
        if (!reset && b_out_valid) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_spurious: got strobe value %0d at cycle %0d, expected no strobe", b_out, cyc);
            end else begin
                eb = qb.pop_front();
                $display("B out cycle %0d value %0d (expected %0d)", cyc, b_out, eb.val);
                check("b_out", b_out, eb.val);
                check("b_out_cycle", cyc, eb.at);
            end
        end
    end

    task automatic send_a(input logic [11:0] v, input bit expect_out, input logic [11:0] ev);
        @(posedge clk); #1;
        a_valid = 1'b1; a_sample = v;
        if (expect_out) qa.push_back('{ev, cyc + 2});
    endtask

    task automatic send_b(input logic [11:0] v, input bit cal, input logic [11:0] ev);
        @(posedge clk); #1;
        b_valid = 1'b1; b_sample = v; b_cal = cal;
        qb.push_back('{ev, cyc + 2});
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        a_valid = 1'b0; a_cal = 1'b0; b_valid = 1'b0; b_cal = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    task automatic check_b_reset_state();
        check("b_rst_out", b_out, 0);
        check("b_rst_valid", b_out_valid, 0);
        check("b_rst_min", b_min, 0);
        check("b_rst_max", b_max, 4095);
        check("b_rst_busy", b_busy, 0);
        check("b_rst_done", b_done, 0);
        check("b_rst_err", b_err, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_b_reset_state();
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_out", a_out, 0);
        check("a_rst_valid", a_out_valid, 0);
        check("a_rst_min", a_min, 0);
        check("a_rst_max", a_max, 4095);
        check("a_rst_busy", a_busy, 0);
        check_b_reset_state();
        reset = 1'b0;

        // Fill: only the 8th sample produces a strobe.
        for (int i = 0; i < 8; i++) send_a(12'd1000, i == 7, 12'd1000);
        for (int i = 0; i < 8; i++) send_a(12'd0, 1'b1, dn_exp[i]);
        for (int i = 0; i < 8; i++) send_a(12'd800, 1'b1, up_exp[i]);
        for (int i = 0; i < 8; i++) send_a(12'd4095, 1'b1, full_exp[i]);
        idle(5);
        check("a_hold_out", a_out, 4095);
        check("a_hold_valid", a_out_valid, 0);

        // Successful calibration, cal_start together with the first sample.
        d0 = b_done_cnt; e0 = b_err_cnt;
        send_b(12'd500, 1'b1, 12'd500);
        send_b(12'd3500, 1'b0, 12'd3500);
        @(negedge clk);
        check("b_busy_cal1", b_busy, 1);
        send_b(12'd2000, 1'b0, 12'd2000);
        send_b(12'd1000, 1'b0, 12'd1000);
        idle(6);
        check("b_done_cal1", b_done_cnt - d0, 1);
        check("b_err_cal1", b_err_cnt - e0, 0);
        check("b_min_cal1", b_min, 500);
        check("b_max_cal1", b_max, 3500);
        check("b_busy_after1", b_busy, 0);
        send_b(12'd100, 1'b0, 12'd500);
        send_b(12'd4000, 1'b0, 12'd3500);
        send_b(12'd2000, 1'b0, 12'd2000);
        idle(4);

        // Span below MIN_SPAN is rejected.
        pulse_reset();
        d0 = b_done_cnt; e0 = b_err_cnt;
        send_b(12'd2000, 1'b1, 12'd2000);
        send_b(12'd2010, 1'b0, 12'd2010);
        send_b(12'd2020, 1'b0, 12'd2020);
        send_b(12'd2030, 1'b0, 12'd2030);
        idle(6);
        check("b_err_cal2", b_err_cnt - e0, 1);
        check("b_done_cal2", b_done_cnt - d0, 0);
        check("b_min_cal2", b_min, 0);
        check("b_max_cal2", b_max, 4095);

        // A second cal_start mid-run must not restart the count.
        d0 = b_done_cnt; e0 = b_err_cnt;
        send_b(12'd1000, 1'b1, 12'd1000);
        send_b(12'd1500, 1'b0, 12'd1500);
        @(negedge clk);
        check("b_busy_cal3", b_busy, 1);
        send_b(12'd3000, 1'b1, 12'd3000);
        send_b(12'd200, 1'b0, 12'd200);
        idle(6);
        check("b_done_cal3", b_done_cnt - d0, 1);
        check("b_err_cal3", b_err_cnt - e0, 0);
        check("b_min_cal3", b_min, 200);
        check("b_max_cal3", b_max, 3000);

        // Reset after two of four samples aborts without any pulse.
        d0 = b_done_cnt; e0 = b_err_cnt;
        send_b(12'd100, 1'b1, 12'd200);
        send_b(12'd4000, 1'b0, 12'd3000);
        idle(4);
        check("b_busy_cal4", b_busy, 1);
        pulse_reset();
        idle(4);
        check("b_done_abort", b_done_cnt - d0, 0);
        check("b_err_abort", b_err_cnt - e0, 0);
        check("b_busy_abort", b_busy, 0);
        check("b_min_abort", b_min, 0);
        check("b_max_abort", b_max, 4095);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_cal_filter.md
ADC_CAL_FILTER -- requirements
Module: adc_cal_filter

Interface
REQ-001 Parameter AVG_LOG2, default 3, log2 of the moving-average depth (legal range 0..6).
REQ-002 Parameter CAL_SAMPLES, default 256, number of filtered outputs observed per calibration run (legal range 1..65535).
REQ-003 Parameter MIN_SPAN, default 64, minimum accepted (max - min) span for a calibration to commit.
REQ-004 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port sample_valid, input, 1, qualifies sample; may be high on consecutive cycles.
REQ-007 Port sample, input, 12, raw unsigned ADC code.
REQ-008 Port cal_start, input, 1, one-cycle request to begin calibration.
REQ-009 Port adc_out, output, 12, filtered code clamped to [adc_min, adc_max].
REQ-010 Port adc_out_valid, output, 1, one-cycle strobe qualifying adc_out.
REQ-011 Port adc_min, output, 12, committed lower calibration limit.
REQ-012 Port adc_max, output, 12, committed upper calibration limit.
REQ-013 Port cal_busy, output, 1, high while the FSM is in CAL or CHECK.
REQ-014 Port cal_done, output, 1, one-cycle pulse on successful commit.
REQ-015 Port cal_err, output, 1, one-cycle pulse on rejected calibration.

Function
REQ-016 Filter: boxcar mean of the last 2^AVG_LOG2 accepted samples, held in a history buffer plus running sum of width 12+AVG_LOG2 (sum += new - oldest); mean = sum >> AVG_LOG2, truncating.
REQ-017 Running sum shall never overflow; 2^AVG_LOG2 samples of 4095 yield mean 4095.
REQ-018 Fill counter: adc_out_valid stays low until 2^AVG_LOG2 samples are accepted since reset; thereafter one strobe per accepted sample.
REQ-019 Latency: sample_valid high in cycle N -> adc_out/adc_out_valid registered and visible in cycle N+2; full throughput of one sample per cycle.
REQ-020 Clamp: adc_out = adc_min if mean < adc_min, adc_max if mean > adc_max, else mean; guarantees adc_min <= adc_out <= adc_max for downstream subtraction.
REQ-021 adc_out holds its last value when adc_out_valid is low.
REQ-022 FSM states IDLE, CAL, CHECK; IDLE -> CAL on cal_start; CAL -> CHECK when the CAL_SAMPLES-th filtered output is counted; CHECK -> IDLE after one cycle.
REQ-023 On entering CAL: working min = 4095, working max = 0, count = 0.
REQ-024 In CAL, each filtered strobe updates working min/max with the unclamped mean and increments count.
REQ-025 CHECK: if (work_max - work_min) >= MIN_SPAN, load adc_min/adc_max from working values and pulse cal_done; else pulse cal_err and leave limits unchanged.
REQ-026 cal_start while in CAL or CHECK is ignored; cal_start and sample_valid in the same cycle both take effect (that sample counts toward CAL only if its strobe arrives after entry).
REQ-027 Clamp always uses committed limits, never working values; new limits apply to outputs from the cycle after commit.
REQ-028 Filtering continues uninterrupted through all FSM states.

Reset
REQ-029 Reset clears history, sum, fill counter, and working registers; FSM to IDLE.
REQ-030 Reset values: adc_out=0, adc_out_valid=0, adc_min=0, adc_max=4095, cal_busy=0, cal_done=0, cal_err=0.
REQ-031 Reset asserted mid-CAL aborts calibration with no cal_done/cal_err pulse and restores default limits.

Verification
REQ-032 AVG_LOG2=3: 8 back-to-back samples of 1000 after reset -> no strobe for samples 1-7; adc_out=1000, valid 2 cycles after sample 8.
REQ-033 AVG_LOG2=3: 8 of 0 then 8 of 800 -> outputs 100,200,...,800 on consecutive strobes; 8 of 4095 -> 4095 (no wrap).
REQ-034 AVG_LOG2=0, CAL_SAMPLES=4: cal_start, samples 500,3500,2000,1000 -> cal_done once, adc_min=500, adc_max=3500, cal_busy low after; then sample 100 -> adc_out 500, sample 4000 -> adc_out 3500.
REQ-035 AVG_LOG2=0, CAL_SAMPLES=4, MIN_SPAN=64: samples 2000,2010,2020,2030 -> cal_err once, limits remain 0/4095.
REQ-036 Second cal_start during CAL -> ignored, exactly one completion pulse; reset after 2 of 4 CAL samples -> no pulse, limits 0/4095, cal_busy=0.
